// File: rtl/la_pkg.sv
// Shared types and defaults for the logic-analyser capture sequencer.
// Holds the address/data width defaults and the sequencer state enum.
package la_pkg;

  localparam int LA_ADDR_W = 10;
  localparam int LA_DATA_W = 8;
  localparam int LA_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_GAP  = 2'd2,
    ST_READ = 2'd3
  } la_state_e;

  // Watchdog counter width; never below one bit.
  function automatic int wd_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/la_ram_mux.sv
// Sample RAM port mux, selected by the registered acquisition/readout
// grants. Purely combinational; with no grant the RAM port is idle (all 0).
//   grant_acq/grant_rd  : owner select
//   acq_wr_*            : acquisition write port
//   rd_addr             : readout address
//   ram_addr/ram_wr_*   : to sample RAM
module la_ram_mux
  import la_pkg::*;
#(
  parameter int ADDR_W = LA_ADDR_W,
  parameter int DATA_W = LA_DATA_W
) (
  input  logic              grant_acq,
  input  logic              grant_rd,
  input  logic [ADDR_W-1:0] acq_wr_addr,
  input  logic [DATA_W-1:0] acq_wr_data,
  input  logic              acq_wr_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              ram_wr_en
);

  always_comb begin
    ram_addr    = '0;
    ram_wr_data = '0;
    ram_wr_en   = 1'b0;
    unique case (1'b1)
      grant_acq: begin
        ram_addr    = acq_wr_addr;
        ram_wr_data = acq_wr_data;
        ram_wr_en   = acq_wr_en;
      end
      grant_rd: begin
        ram_addr = rd_addr;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/capture_sequencer.sv
// Capture sequencer: IDLE -> ACQ -> GAP -> READ -> IDLE, arbitrating the
// sample RAM between acquisition and readout with a one-cycle gap.
// Ports: clk, rst (sync, active-low); start/abort control; busy, done,
//   err, capture_cnt status; grant_acq/done_acq and acq_wr_* from the
//   acquisition block; grant_rd/done_rd/rd_addr from readout; ram_* out.
// Optional macro ACQ_TIMEOUT_EN adds an ACQ watchdog (TIMEOUT_CYCLES)
//   that returns to IDLE and sets sticky err; otherwise err is tied 0.
module capture_sequencer
  import la_pkg::*;
#(
  parameter int ADDR_W         = LA_ADDR_W,
  parameter int DATA_W         = LA_DATA_W,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        capture_cnt,
  output logic              grant_acq,
  input  logic              done_acq,
  input  logic [ADDR_W-1:0] acq_wr_addr,
  input  logic [DATA_W-1:0] acq_wr_data,
  input  logic              acq_wr_en,
  output logic              grant_rd,
  input  logic              done_rd,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              ram_wr_en
);

  la_state_e      state_q;
  la_state_e      state_d;
  logic           done_q;
  logic           done_d;
  logic [7:0]     cnt_q;
  logic [7:0]     cnt_d;
  logic           gacq_q;
  logic           grd_q;
  logic           acq_start;
  logic           wd_hit;

  assign acq_start = (state_q == ST_IDLE) && start;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_ACQ;
      end
      ST_ACQ: begin
        // abort beats done_acq, which beats the watchdog
        if (abort)         state_d = ST_IDLE;
        else if (done_acq) state_d = ST_GAP;
        else if (wd_hit)   state_d = ST_IDLE;
      end
      ST_GAP: begin
        state_d = ST_READ;
      end
      ST_READ: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (done_rd) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Grants are decoded from the next state so they line up
  // exactly with the state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      gacq_q  <= 1'b0;
      grd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      gacq_q  <= (state_d == ST_ACQ);
      grd_q   <= (state_d == ST_READ);
    end
  end

`ifdef ACQ_TIMEOUT_EN
  localparam int WD_W = wd_width(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q;
  logic            err_q;

  assign wd_hit = (wd_q == WD_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wd_q <= '0;
    end else if (acq_start) begin
      wd_q <= '0;
    end else if (state_q == ST_ACQ) begin
      wd_q <= wd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (acq_start) begin
      err_q <= 1'b0;
    end else if (state_q == ST_ACQ && !abort
                 && !done_acq && wd_hit) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign wd_hit = 1'b0;
  assign err    = 1'b0;
`endif

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign capture_cnt = cnt_q;
  assign grant_acq   = gacq_q;
  assign grant_rd    = grd_q;

  la_ram_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mux (
    .grant_acq   (gacq_q),
    .grant_rd    (grd_q),
    .acq_wr_addr (acq_wr_addr),
    .acq_wr_data (acq_wr_data),
    .acq_wr_en   (acq_wr_en),
    .rd_addr     (rd_addr),
    .ram_addr    (ram_addr),
    .ram_wr_data (ram_wr_data),
    .ram_wr_en   (ram_wr_en)
  );

endmodule

// File: tb/tb_capture_sequencer.sv
// Self-checking bench for capture_sequencer: directed stimulus, with
// expected capture counts queued and checked on each done pulse.
module tb_capture_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  capture_cnt;
  logic        grant_acq;
  logic        done_acq;
  logic [9:0]  acq_wr_addr;
  logic [7:0]  acq_wr_data;
  logic        acq_wr_en;
  logic        grant_rd;
  logic        done_rd;
  logic [9:0]  rd_addr;
  logic [9:0]  ram_addr;
  logic [7:0]  ram_wr_data;
  logic        ram_wr_en;

  int n_chk;
  int n_fail;
  logic [7:0] exp_q[$];

  capture_sequencer #(
    .ADDR_W         (10),
    .DATA_W         (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .capture_cnt (capture_cnt),
    .grant_acq   (grant_acq),
    .done_acq    (done_acq),
    .acq_wr_addr (acq_wr_addr),
    .acq_wr_data (acq_wr_data),
    .acq_wr_en   (acq_wr_en),
    .grant_rd    (grant_rd),
    .done_rd     (done_rd),
    .rd_addr     (rd_addr),
    .ram_addr    (ram_addr),
    .ram_wr_data (ram_wr_data),
    .ram_wr_en   (ram_wr_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every done pulse must match a queued count.
  always @(negedge clk) begin
    if (rst) begin
      n_chk++;
      if (grant_acq && grant_rd) begin
        n_fail++;
        $display("FAIL grant_mutex: both grants high");
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL done_unexp: got done=1 expected none");
        end else begin
          check("done_cnt", 32'(capture_cnt),
                32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic capture(input int acq_n, input int rd_n,
                         input logic [7:0] exp_cnt);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (acq_n) tick();
    done_acq = 1'b1;
    tick();
    done_acq = 1'b0;
    tick();
    repeat (rd_n) tick();
    done_rd = 1'b1;
    exp_q.push_back(exp_cnt);
    tick();
    done_rd = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_cnt"}, 32'(capture_cnt), 0);
    check({tag, "_gacq"}, 32'(grant_acq), 0);
    check({tag, "_grd"}, 32'(grant_rd), 0);
    check({tag, "_raddr"}, 32'(ram_addr), 0);
    check({tag, "_rwe"}, 32'(ram_wr_en), 0);
  endtask

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    rst         = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    done_acq    = 1'b0;
    done_rd     = 1'b0;
    acq_wr_addr = '0;
    acq_wr_data = '0;
    acq_wr_en   = 1'b0;
    rd_addr     = '0;
    repeat (3) tick();
    check_all_zero("rst");
    rst = 1'b1;
    tick();
    check_all_zero("idle");

    // Normal capture with 1024 writes
    start = 1'b1;
    tick();
    start = 1'b0;
    check("acq_gacq", 32'(grant_acq), 1);
    check("acq_grd", 32'(grant_rd), 0);
    check("acq_busy", 32'(busy), 1);
    for (int i = 0; i < 1024; i++) begin
      acq_wr_addr = 10'(i);
      acq_wr_data = (i == 1023) ? 8'hA5 : 8'(i);
      acq_wr_en   = 1'b1;
      #1;
      if (i == 0) begin
        check("mux0_addr", 32'(ram_addr), 0);
        check("mux0_we", 32'(ram_wr_en), 1);
      end
      if (i == 1023) begin
        check("mux_addr", 32'(ram_addr), 32'h3FF);
        check("mux_data", 32'(ram_wr_data), 32'hA5);
        check("mux_we", 32'(ram_wr_en), 1);
      end
      tick();
    end
    check("acq_hold", 32'(grant_acq), 1);
    done_acq = 1'b1;
    tick();
    done_acq = 1'b0;
    #1;
    check("gap_gacq", 32'(grant_acq), 0);
    check("gap_grd", 32'(grant_rd), 0);
    check("gap_busy", 32'(busy), 1);
    check("gap_raddr", 32'(ram_addr), 0);
    check("gap_rdata", 32'(ram_wr_data), 0);
    check("gap_rwe", 32'(ram_wr_en), 0);
    tick();
    check("rd_grd", 32'(grant_rd), 1);
    check("rd_gacq", 32'(grant_acq), 0);
    rd_addr = 10'h155;
    #1;
    check("rd_raddr", 32'(ram_addr), 32'h155);
    check("rd_rwe", 32'(ram_wr_en), 0);
    // start during READ is ignored, even with done_rd
    start = 1'b1;
    repeat (18) tick();
    check("rd_start_ign", 32'(grant_rd), 1);
    done_rd = 1'b1;
    exp_q.push_back(8'd1);
    tick();
    done_rd   = 1'b0;
    start     = 1'b0;
    acq_wr_en = 1'b0;
    check("done_pulse", 32'(done), 1);
    check("idle_after", 32'(busy), 0);
    check("cnt_one", 32'(capture_cnt), 1);
    tick();
    check("done_one_cyc", 32'(done), 0);
    check("start_rd_ign", 32'(busy), 0);

    // Abort with simultaneous done_acq
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    abort    = 1'b1;
    done_acq = 1'b1;
    tick();
    abort    = 1'b0;
    done_acq = 1'b0;
    check("ab_busy", 32'(busy), 0);
    check("ab_gacq", 32'(grant_acq), 0);
    for (int i = 0; i < 3; i++) begin
      check("ab_no_grd", 32'(grant_rd), 0);
      tick();
    end
    check("ab_cnt", 32'(capture_cnt), 1);

    // Abort with simultaneous done_rd
    start = 1'b1;
    tick();
    start    = 1'b0;
    done_acq = 1'b1;
    tick();
    done_acq = 1'b0;
    tick();
    check("ab2_grd", 32'(grant_rd), 1);
    abort   = 1'b1;
    done_rd = 1'b1;
    tick();
    abort   = 1'b0;
    done_rd = 1'b0;
    check("ab2_busy", 32'(busy), 0);
    check("ab2_grd0", 32'(grant_rd), 0);
    check("ab2_done", 32'(done), 0);
    check("ab2_cnt", 32'(capture_cnt), 1);

    // Reset mid-READ
    start = 1'b1;
    tick();
    start    = 1'b0;
    done_acq = 1'b1;
    tick();
    done_acq = 1'b0;
    tick();
    rd_addr = 10'h155;
    rst     = 1'b0;
    tick();
    check_all_zero("rd_rst");
    rst = 1'b1;
    tick();
    check("post_rst_busy", 32'(busy), 0);

    // 256 captures wrap the counter
    for (int i = 1; i <= 256; i++) capture(1, 0, 8'(i));
    check("wrap_cnt", 32'(capture_cnt), 0);
    tick();

`ifdef ACQ_TIMEOUT_EN
    begin
      int n;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (grant_acq && n < 100) begin
        n++;
        tick();
      end
      check("wd_cycles", 32'(n), 16);
      check("wd_err", 32'(err), 1);
      check("wd_busy", 32'(busy), 0);
      repeat (3) tick();
      check("wd_sticky", 32'(err), 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("wd_clr", 32'(err), 0);
      check("wd_reacq", 32'(grant_acq), 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end
`else
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (40) tick();
    check("nowd_wait", 32'(grant_acq), 1);
    check("nowd_err", 32'(err), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
`endif

    repeat (3) tick();
    check("sb_drain", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
